demux_1to7: RTL and testbench

Registered 1:7 demultiplexer: the transmit-side counterpart of the team's 7:1 output mux. One 8-bit input stream with a valid/ready handshake is steered by `{sel2, sel1, sel0}` into one of seven output channels. Each channel has its own one-deep holding register and handshake. The block fans one producer out to seven independent consumers. Select 3'b111 aliases channel 6, exactly mirroring the mux's select map.

---
 rtl/demux_pkg.sv | 9 +
 rtl/demux_slot.sv | 42 ++++
 rtl/demux_1to7.sv | 65 ++++++
 tb/tb_demux_1to7.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared channel count, select type and select-to-channel decode for demux_1to7
package demux_pkg;
  localparam int NUM_CH = 7;
  localparam int CNT_W = 8;
  typedef logic [2:0] sel_t;
  function automatic logic [2:0] sel_to_ch(input sel_t s);
    return (s == 3'd7) ? 3'd6 : s;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-deep channel holding register with full flag and load/drain handshake
// optional per-channel transfer counter under DEMUX_CNT_EN
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] o_cnt
`endif
);
  logic             r_full;
  logic [WIDTH-1:0] r_data;
  // a load in the same cycle as a drain keeps the slot full with the new word
  always_ff @(posedge clk)
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_ready) begin
      r_full <= 1'b0;
    end
  assign o_data = r_data;
  assign o_full = r_full;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
`endif
endmodule

// File: rtl/demux_1to7.sv
// demux_1to7: registered 1:7 demux with per-channel valid/ready; select 7 aliases channel 6
// DEMUX_CNT_EN adds per-channel accept counters and the cnt readback port
module demux_1to7
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  i,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              sel0,
  input  logic              sel1,
  input  logic              sel2,
  output logic [WIDTH-1:0]  o0,
  output logic [WIDTH-1:0]  o1,
  output logic [WIDTH-1:0]  o2,
  output logic [WIDTH-1:0]  o3,
  output logic [WIDTH-1:0]  o4,
  output logic [WIDTH-1:0]  o5,
  output logic [WIDTH-1:0]  o6,
  output logic [NUM_CH-1:0] o_valid,
  input  logic [NUM_CH-1:0] o_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt
`endif
);
  logic [2:0]        w_ch;
  logic [NUM_CH-1:0] w_load;
  logic [WIDTH-1:0]  w_data [NUM_CH];
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0]  w_cnt [NUM_CH];
`endif
  assign w_ch = sel_to_ch({sel2, sel1, sel0});
  // only the addressed channel can stall the producer
  assign i_ready = !o_valid[w_ch] | o_ready[w_ch];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    assign w_load[g] = i_valid & i_ready & (w_ch == 3'(g));
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load[g]),
      .i_data (i),
      .i_ready(o_ready[g]),
      .o_data (w_data[g]),
      .o_full (o_valid[g])
`ifdef DEMUX_CNT_EN
      ,
      .o_cnt  (w_cnt[g])
`endif
    );
  end
  assign o0 = w_data[0];
  assign o1 = w_data[1];
  assign o2 = w_data[2];
  assign o3 = w_data[3];
  assign o4 = w_data[4];
  assign o5 = w_data[5];
  assign o6 = w_data[6];
`ifdef DEMUX_CNT_EN
  assign cnt = w_cnt[w_ch];
`endif
endmodule

// File: tb/tb_demux_1to7.sv
// tb_demux_1to7: scoreboard bench for demux_1to7; covers the cnt port when DEMUX_CNT_EN is defined
module tb_demux_1to7;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i = '0;
  logic [2:0] sel = '0;
  logic [6:0] o_ready = '0;
  logic       i_ready;
  logic [6:0] o_valid;
  logic [7:0] o_arr [7];
`ifdef DEMUX_CNT_EN
  logic [7:0] cnt;
  logic [7:0] m_cnt [7];
`endif
  logic [7:0] sb_q [7][$];
  logic [7:0] m_last [7];
  bit         armed = 1'b0;
  bit         acc = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  demux_1to7 dut (
    .clk    (clk),
    .rst    (rst),
    .i      (i),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .sel0   (sel[0]),
    .sel1   (sel[1]),
    .sel2   (sel[2]),
    .o0     (o_arr[0]),
    .o1     (o_arr[1]),
    .o2     (o_arr[2]),
    .o3     (o_arr[3]),
    .o4     (o_arr[4]),
    .o5     (o_arr[5]),
    .o6     (o_arr[6]),
    .o_valid(o_valid),
    .o_ready(o_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt    (cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ch_of(input logic [2:0] s);
    return (s == 3'd7) ? 6 : int'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s, input logic [7:0] d);
    int k = 0;
    sel = s;
    i = d;
    i_valid = 1'b1;
    @(negedge clk);
    while (!i_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) check("send_timeout", i_ready, 1);
    step();
    i_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    int c;
    bit er;
    c = ch_of(sel);
    er = sb_q[c].size() == 0 || o_ready[c];
    if (armed) begin
      for (int n = 0; n < 7; n++) begin
        check("o_valid", o_valid[n], sb_q[n].size() != 0);
        check("o_data", o_arr[n], m_last[n]);
      end
      check("i_ready", i_ready, er);
`ifdef DEMUX_CNT_EN
      check("cnt", cnt, m_cnt[c]);
`endif
    end
    if (rst) begin
      for (int n = 0; n < 7; n++) begin
        sb_q[n].delete();
        m_last[n] = '0;
`ifdef DEMUX_CNT_EN
        m_cnt[n] = '0;
`endif
      end
      armed = 1'b1;
    end else if (armed) begin
      for (int n = 0; n < 7; n++)
        if (sb_q[n].size() != 0 && o_ready[n]) check("drain", o_arr[n], sb_q[n].pop_front());
      if (i_valid && er) begin
        sb_q[c].push_back(i);
        m_last[c] = i;
`ifdef DEMUX_CNT_EN
        m_cnt[c] = m_cnt[c] + 8'd1;
`endif
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", o_valid, 7'b0);
    for (int n = 0; n < 7; n++) check("rst_data", o_arr[n], 8'h00);
    check("rst_ready", i_ready, 1);
    step();
    send(3'd3, 8'hA5);
    @(negedge clk);
    check("t1_valid", o_valid, 7'b0001000);
    check("t1_o3", o_arr[3], 8'hA5);
    check("t1_stall", i_ready, 0);
    step();
    send(3'd0, 8'h11);
    @(negedge clk);
    check("t2_o0", o_arr[0], 8'h11);
    check("t2_valid", o_valid, 7'b0001001);
    step();
    o_ready = 7'b0001000;
    @(negedge clk);
    check("t2_hold3", o_valid[3], 1);
    step();
    @(negedge clk);
    check("t2_drain3", o_valid, 7'b0000001);
    step();
    o_ready = 7'b0000100;
    sel = 3'd2;
    for (int k = 1; k <= 8; k++) begin
      i = 8'(k);
      i_valid = 1'b1;
      @(negedge clk);
      check("t3_ready", i_ready, 1);
      if (k > 1) check("t3_o2", o_arr[2], 8'(k - 1));
      step();
    end
    i_valid = 1'b0;
    @(negedge clk);
    check("t3_last", o_arr[2], 8'h08);
    step();
    o_ready = '0;
    send(3'd7, 8'h7E);
    @(negedge clk);
    check("t4_valid", o_valid, 7'b1000001);
    check("t4_o6", o_arr[6], 8'h7E);
    step();
    send(3'd1, 8'h31);
    send(3'd5, 8'h55);
    o_ready = 7'b0000010;
    sel = 3'd1;
    i = 8'hFF;
    i_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_ready", i_ready, 1);
    step();
    rst = 1'b0;
    i_valid = 1'b0;
    o_ready = '0;
    @(negedge clk);
    check("t5_valid", o_valid, 7'b0);
    check("t5_o1", o_arr[1], 8'h00);
    step();
`ifdef DEMUX_CNT_EN
    o_ready = 7'b0010000;
    sel = 3'd4;
    i_valid = 1'b1;
    for (int k = 0; k < 257; k++) begin
      i = 8'(k);
      step();
    end
    i_valid = 1'b0;
    @(negedge clk);
    check("t6_cnt4", cnt, 8'h01);
    step();
    sel = 3'd0;
    @(negedge clk);
    check("t6_cnt0", cnt, 8'h00);
    step();
`endif
    acc = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!i_valid || acc) begin
        i_valid = $urandom_range(0, 3) != 0;
        sel = 3'($urandom_range(0, 7));
        i = 8'($urandom);
      end
      o_ready = 7'($urandom);
      @(negedge clk);
      acc = i_valid && i_ready;
      step();
    end
    i_valid = 1'b0;
    o_ready = '1;
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
